// File: rtl/fdiv_iter.sv
// Iterative IEEE-754 single-precision divider: restoring division producing one
// quotient bit per cycle, round-to-nearest-even, denormals flushed to zero.
module fdiv_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] x1_i,
  input  logic [31:0] x2_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] y_o,
  output logic        ovf_o,
  output logic        udf_o
);
  localparam int QBITS = 26;

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_e;

  state_e             state_q, state_d;
  logic [4:0]         cnt_q;
  logic [QBITS-1:0]   q_q;
  logic [24:0]        r_q;
  logic [23:0]        m2_q;
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic               spec_q;
  logic [31:0]        spec_y_q;
  logic               spec_ovf_q;
  logic [31:0]        y_q;
  logic               ovf_q;
  logic               udf_q;
  logic               out_valid_q;

  logic               accept;
  logic               out_hs;
  logic               sign_in;
  logic               a_zero, b_zero, a_inf, b_inf;
  logic               special;
  logic [31:0]        special_y;
  logic               special_ovf;

  assign accept  = (state_q == IDLE) && in_valid_i;
  assign out_hs  = out_valid_q && out_ready_i;
  assign sign_in = x1_i[31] ^ x2_i[31];
  assign a_zero  = (x1_i[30:23] == 8'h00);
  assign b_zero  = (x2_i[30:23] == 8'h00);
  assign a_inf   = (x1_i[30:23] == 8'hFF);
  assign b_inf   = (x2_i[30:23] == 8'hFF);

  // Operands that bypass the divider; infinities/NaNs dominate, then 0/0.
  always_comb begin
    special     = 1'b1;
    special_y   = {sign_in, 8'hFF, 23'd0};
    special_ovf = 1'b1;
    if (a_inf || b_inf) begin
      special_y = {sign_in, 8'hFF, 23'd0};
    end else if (a_zero && b_zero) begin
      special_y = 32'h7FC0_0000;
    end else if (b_zero) begin
      special_y = {sign_in, 8'hFF, 23'd0};
    end else if (a_zero) begin
      special_y   = {sign_in, 31'd0};
      special_ovf = 1'b0;
    end else begin
      special = 1'b0;
    end
  end

  // One restoring step: remainder stays below 2*m2, so 25 bits suffice.
  logic [25:0] r_diff;
  logic        q_bit;
  logic [24:0] r_step;
  assign r_diff = {1'b0, r_q} - {2'b00, m2_q};
  assign q_bit  = ~r_diff[25];
  assign r_step = q_bit ? r_diff[24:0] : r_q;

  logic               q_top;
  logic [23:0]        mant_pre;
  logic               guard, sticky, inc;
  logic [24:0]        mant_sum;
  logic [23:0]        mant_fin;
  logic signed [9:0]  bias;
  logic signed [9:0]  exp_r;
  logic [31:0]        round_y;
  logic               round_ovf, round_udf;

  always_comb begin
    q_top    = q_q[QBITS-1];
    mant_pre = q_top ? q_q[25:2] : q_q[24:1];
    guard    = q_top ? q_q[1] : q_q[0];
    sticky   = (q_top & q_q[0]) | (r_q != 25'd0);
    inc      = guard & (sticky | mant_pre[0]);
    mant_sum = {1'b0, mant_pre} + {24'd0, inc};
    mant_fin = mant_sum[24] ? 24'h80_0000 : mant_sum[23:0];
    bias     = q_top ? 10'sd127 : 10'sd126;
    exp_r    = exp_q + bias + $signed({9'd0, mant_sum[24]});
    round_y   = {sign_q, exp_r[7:0], mant_fin[22:0]};
    round_ovf = 1'b0;
    round_udf = 1'b0;
    if (exp_r >= 10'sd255) begin
      round_y   = {sign_q, 8'hFF, 23'd0};
      round_ovf = 1'b1;
    end else if (exp_r <= 10'sd0) begin
      round_y   = {sign_q, 31'd0};
      round_udf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i) state_d = special ? ROUND : DIV;
      DIV:     if (cnt_q == 5'(QBITS - 1)) state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    if (out_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = out_valid_q;
    y_o         = y_q;
    ovf_o       = ovf_q;
    udf_o       = udf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 5'd0;
      q_q         <= '0;
      r_q         <= 25'd0;
      m2_q        <= 24'd0;
      sign_q      <= 1'b0;
      exp_q       <= 10'sd0;
      spec_q      <= 1'b0;
      spec_y_q    <= 32'd0;
      spec_ovf_q  <= 1'b0;
      y_q         <= 32'd0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // The result is registered once more after DONE is entered.
      out_valid_q <= (state_q == DONE) && !out_hs;
      case (state_q)
        IDLE: begin
          if (accept) begin
            sign_q     <= sign_in;
            exp_q      <= $signed({2'b00, x1_i[30:23]}) - $signed({2'b00, x2_i[30:23]});
            r_q        <= {2'b01, x1_i[22:0]};
            m2_q       <= {1'b1, x2_i[22:0]};
            q_q        <= '0;
            cnt_q      <= 5'd0;
            spec_q     <= special;
            spec_y_q   <= special_y;
            spec_ovf_q <= special_ovf;
          end
        end
        DIV: begin
          q_q   <= {q_q[QBITS-2:0], q_bit};
          r_q   <= {r_step[23:0], 1'b0};
          cnt_q <= cnt_q + 5'd1;
        end
        ROUND: begin
          y_q   <= spec_q ? spec_y_q : round_y;
          ovf_q <= spec_q ? spec_ovf_q : round_ovf;
          udf_q <= spec_q ? 1'b0 : round_udf;
        end
        DONE: begin
          if (out_hs) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
